// File: rtl/ycbcr2rgb.sv
// BT.601 studio-range YCbCr to RGB converter: 3-stage fixed-point pipeline with valid/ready and global stall.
// Optional saturated-pixel counter enabled by defining YCBCR2RGB_SAT_CNT_EN.
module ycbcr2rgb #(
    parameter int DATA_WIDTH    = 8,
    parameter int COEF_FRAC     = 10,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic [DATA_WIDTH-1:0] cb,
    input  logic [DATA_WIDTH-1:0] cr,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] r,
    output logic [DATA_WIDTH-1:0] g,
    output logic [DATA_WIDTH-1:0] b
`ifdef YCBCR2RGB_SAT_CNT_EN
    ,
    output logic [SAT_CNT_WIDTH-1:0] o_sat_cnt
`endif
);

    localparam int DW1 = DATA_WIDTH + 1;
    localparam int IW  = DATA_WIDTH + COEF_FRAC + 6;
    localparam int K   = DATA_WIDTH - 8;

    if (DATA_WIDTH < 8 || DATA_WIDTH > 12) begin : g_bad_data_width
        $error("ycbcr2rgb: DATA_WIDTH must be within 8..12");
    end
    if (COEF_FRAC < 1 || SAT_CNT_WIDTH < 1) begin : g_bad_params
        $error("ycbcr2rgb: COEF_FRAC and SAT_CNT_WIDTH must be positive");
    end

    // Coefficients are given in Q10 and rescaled (rounded) to COEF_FRAC fractional bits.
    function automatic int scale_coef(input int q10);
        return (q10 * (1 << COEF_FRAC) + 512) / 1024;
    endfunction

    localparam logic signed [IW-1:0]  CY      = IW'(scale_coef(1192));
    localparam logic signed [IW-1:0]  CRR     = IW'(scale_coef(1634));
    localparam logic signed [IW-1:0]  CGB     = IW'(scale_coef(401));
    localparam logic signed [IW-1:0]  CGR     = IW'(scale_coef(833));
    localparam logic signed [IW-1:0]  CBB     = IW'(scale_coef(2066));
    localparam logic signed [DW1-1:0] YOFF    = DW1'(16 << K);
    localparam logic signed [DW1-1:0] COFF    = DW1'(128 << K);
    localparam logic signed [IW-1:0]  RND     = IW'(1 << (COEF_FRAC - 1));
    localparam logic signed [IW-1:0]  PIX_MAX = IW'((1 << DATA_WIDTH) - 1);

    function automatic logic signed [IW-1:0] round_q(input logic signed [IW-1:0] v);
        return (v + RND) >>> COEF_FRAC;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] clamp_pix(input logic signed [IW-1:0] v);
        if (v[IW-1]) begin
            return '0;
        end else if (v > PIX_MAX) begin
            return '1;
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    logic advance;

    logic vld_p1_q, vld_p2_q, vld_p3_q;

    logic signed [DW1-1:0] dy_p1_d, dy_p1_q;
    logic signed [DW1-1:0] dcb_p1_d, dcb_p1_q;
    logic signed [DW1-1:0] dcr_p1_d, dcr_p1_q;

    logic signed [IW-1:0] py_p2_d, py_p2_q;
    logic signed [IW-1:0] prr_p2_d, prr_p2_q;
    logic signed [IW-1:0] pgb_p2_d, pgb_p2_q;
    logic signed [IW-1:0] pgr_p2_d, pgr_p2_q;
    logic signed [IW-1:0] pbb_p2_d, pbb_p2_q;

    logic signed [IW-1:0] rsum_p3, gsum_p3, bsum_p3;
    logic signed [IW-1:0] rrnd_p3, grnd_p3, brnd_p3;
    logic [DATA_WIDTH-1:0] r_p3_d, r_p3_q;
    logic [DATA_WIDTH-1:0] g_p3_d, g_p3_q;
    logic [DATA_WIDTH-1:0] b_p3_d, b_p3_q;

    // Global stall: every stage moves only when the output slot is free or being drained.
    assign advance = ~vld_p3_q | o_ready;
    assign i_ready = advance;
    assign o_valid = vld_p3_q;
    assign r       = r_p3_q;
    assign g       = g_p3_q;
    assign b       = b_p3_q;

    always_comb begin
        // stage 1: remove the studio-range offsets
        dy_p1_d  = $signed({1'b0, y}) - YOFF;
        dcb_p1_d = $signed({1'b0, cb}) - COFF;
        dcr_p1_d = $signed({1'b0, cr}) - COFF;

        // stage 2: coefficient products
        py_p2_d  = IW'(dy_p1_q) * CY;
        prr_p2_d = IW'(dcr_p1_q) * CRR;
        pgb_p2_d = IW'(dcb_p1_q) * CGB;
        pgr_p2_d = IW'(dcr_p1_q) * CGR;
        pbb_p2_d = IW'(dcb_p1_q) * CBB;

        // stage 3: sum, round, clamp
        rsum_p3 = py_p2_q + prr_p2_q;
        gsum_p3 = py_p2_q - pgb_p2_q - pgr_p2_q;
        bsum_p3 = py_p2_q + pbb_p2_q;
        rrnd_p3 = round_q(rsum_p3);
        grnd_p3 = round_q(gsum_p3);
        brnd_p3 = round_q(bsum_p3);
        r_p3_d  = clamp_pix(rrnd_p3);
        g_p3_d  = clamp_pix(grnd_p3);
        b_p3_d  = clamp_pix(brnd_p3);
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            dy_p1_q  <= dy_p1_d;
            dcb_p1_q <= dcb_p1_d;
            dcr_p1_q <= dcr_p1_d;
            py_p2_q  <= py_p2_d;
            prr_p2_q <= prr_p2_d;
            pgb_p2_q <= pgb_p2_d;
            pgr_p2_q <= pgr_p2_d;
            pbb_p2_q <= pbb_p2_d;
        end
    end

    // Valid bits and the visible output registers are the only reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            r_p3_q   <= '0;
            g_p3_q   <= '0;
            b_p3_q   <= '0;
        end else if (advance) begin
            vld_p1_q <= i_valid;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            r_p3_q   <= r_p3_d;
            g_p3_q   <= g_p3_d;
            b_p3_q   <= b_p3_d;
        end
    end

`ifdef YCBCR2RGB_SAT_CNT_EN
    function automatic logic is_clamped(input logic signed [IW-1:0] v);
        return v[IW-1] || (v > PIX_MAX);
    endfunction

    logic                     sat_p3_d, sat_p3_q;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_d, sat_cnt_q;

    always_comb begin
        sat_p3_d  = is_clamped(rrnd_p3) | is_clamped(grnd_p3) | is_clamped(brnd_p3);
        sat_cnt_d = sat_cnt_q;
        // Count on consumption so a stalled pixel is counted once; stick at all-ones.
        if (vld_p3_q && o_ready && sat_p3_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_p3_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            if (advance) begin
                sat_p3_q <= sat_p3_d;
            end
        end
    end

    assign o_sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed testbench for ycbcr2rgb: latency, colour values, streaming, back-pressure, reset, optional counter.
module tb_ycbcr2rgb;

    logic       clk = 1'b0;
    logic       rst, i_valid, i_ready, o_valid, o_ready;
    logic [7:0] y, cb, cr, r, g, b;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

`ifdef YCBCR2RGB_SAT_CNT_EN
    logic [3:0] sat_cnt;
    ycbcr2rgb #(.DATA_WIDTH(8), .COEF_FRAC(10), .SAT_CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .y(y), .cb(cb), .cr(cr), .o_valid(o_valid), .o_ready(o_ready),
        .r(r), .g(g), .b(b), .o_sat_cnt(sat_cnt));
`else
    ycbcr2rgb #(.DATA_WIDTH(8), .COEF_FRAC(10)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .y(y), .cb(cb), .cr(cr), .o_valid(o_valid), .o_ready(o_ready),
        .r(r), .g(g), .b(b));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] clamp8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [23:0] model(input logic [7:0] yy, input logic [7:0] cc_b, input logic [7:0] cc_r);
        int dy, dcb, dcr, rv, gv, bv;
        dy  = int'(yy) - 16;
        dcb = int'(cc_b) - 128;
        dcr = int'(cc_r) - 128;
        rv  = (1192 * dy + 1634 * dcr + 512) >>> 10;
        gv  = (1192 * dy - 401 * dcb - 833 * dcr + 512) >>> 10;
        bv  = (1192 * dy + 2066 * dcb + 512) >>> 10;
        return {clamp8(rv), clamp8(gv), clamp8(bv)};
    endfunction

    task automatic send_one(input string tag, input logic [7:0] yy, input logic [7:0] cc_b,
                            input logic [7:0] cc_r, input logic [23:0] exp_rgb);
        y = yy; cb = cc_b; cr = cc_r; i_valid = 1'b1; o_ready = 1'b1;
        #2 chk({tag, "_irdy"}, i_ready, 1);
        tick();
        i_valid = 1'b0;
        chk({tag, "_lat1"}, o_valid, 0);
        tick();
        chk({tag, "_lat2"}, o_valid, 0);
        tick();
        chk({tag, "_lat3"}, o_valid, 1);
        chk({tag, "_rgb"}, {r, g, b}, exp_rgb);
        tick();
        chk({tag, "_drained"}, o_valid, 0);
    endtask

    logic [23:0] expq[$];
    logic [7:0]  bpy[6]  = '{8'd16, 8'd235, 8'd81, 8'd145, 8'd41, 8'd128};
    logic [7:0]  bpcb[6] = '{8'd128, 8'd128, 8'd90, 8'd54, 8'd240, 8'd128};
    logic [7:0]  bpcr[6] = '{8'd128, 8'd128, 8'd240, 8'd34, 8'd110, 8'd128};
    logic [23:0] bexp[6];

    initial begin
        int first_out, last_out, got, sent, in_idx, out_idx;
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; y = '0; cb = '0; cr = '0;
        tick();
        tick();
        chk("rst_ovalid", o_valid, 0);
        chk("rst_rgb", {r, g, b}, 0);
`ifdef YCBCR2RGB_SAT_CNT_EN
        chk("rst_satcnt", sat_cnt, 0);
`endif
        rst = 1'b0;
        tick();
        chk("post_rst_irdy", i_ready, 1);

        send_one("black", 8'd16, 8'd128, 8'd128, 24'h000000);
`ifdef YCBCR2RGB_SAT_CNT_EN
        chk("black_satcnt", sat_cnt, 0);
`endif
        send_one("white", 8'd235, 8'd128, 8'd128, 24'hFFFFFF);
`ifdef YCBCR2RGB_SAT_CNT_EN
        chk("white_satcnt", sat_cnt, 0);
`endif
        send_one("red", 8'd81, 8'd90, 8'd240, {8'd254, 8'd0, 8'd0});
`ifdef YCBCR2RGB_SAT_CNT_EN
        chk("red_satcnt", sat_cnt, 1);
`endif

        // Continuous streaming with the sink always ready.
        first_out = -1; last_out = -1; got = 0; sent = 0;
        o_ready = 1'b1;
        for (int it = 0; it < 220 && got < 100; it++) begin
            if (o_valid) begin
                if (first_out < 0) first_out = it;
                last_out = it;
                chk("stream_have_exp", expq.size() > 0, 1);
                if (expq.size() > 0) chk("stream_pix", {r, g, b}, expq.pop_front());
                got++;
            end
            if (sent < 100) begin
                y = 8'($urandom_range(0, 255));
                cb = 8'($urandom_range(0, 255));
                cr = 8'($urandom_range(0, 255));
                i_valid = 1'b1;
                expq.push_back(model(y, cb, cr));
                sent++;
            end else begin
                i_valid = 1'b0;
            end
            tick();
        end
        i_valid = 1'b0;
        chk("stream_count", got, 100);
        chk("stream_first", first_out, 3);
        chk("stream_last", last_out, 102);

        // Back-pressure: sink stalled from the start.
        for (int k = 0; k < 6; k++) bexp[k] = model(bpy[k], bpcb[k], bpcr[k]);
        o_ready = 1'b0; in_idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (in_idx < 6) begin
                y = bpy[in_idx]; cb = bpcb[in_idx]; cr = bpcr[in_idx]; i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #2 if (i_valid && i_ready) in_idx++;
            tick();
        end
        chk("bp_accepted", in_idx, 3);
        chk("bp_irdy_low", i_ready, 0);
        chk("bp_ovalid", o_valid, 1);
        chk("bp_hold0", {r, g, b}, bexp[0]);
        tick();
        chk("bp_hold1_valid", o_valid, 1);
        chk("bp_hold1", {r, g, b}, bexp[0]);
        o_ready = 1'b1; out_idx = 0;
        for (int c = 0; c < 30 && out_idx < 6; c++) begin
            if (o_valid) begin
                chk("bp_order", {r, g, b}, bexp[out_idx]);
                out_idx++;
            end
            if (in_idx < 6) begin
                y = bpy[in_idx]; cb = bpcb[in_idx]; cr = bpcr[in_idx]; i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #2 if (i_valid && i_ready) in_idx++;
            tick();
        end
        i_valid = 1'b0;
        chk("bp_out_count", out_idx, 6);
        chk("bp_in_count", in_idx, 6);
        chk("bp_drained", o_valid, 0);

        // Reset lands on the edge where the first in-flight pixel would reach the output.
        o_ready = 1'b1;
        y = 8'd235; cb = 8'd128; cr = 8'd128; i_valid = 1'b1;
        tick();
        y = 8'd81; cb = 8'd90; cr = 8'd240;
        tick();
        i_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ovalid", o_valid, 0);
        chk("midrst_rgb", {r, g, b}, 0);
        chk("midrst_irdy", i_ready, 1);
`ifdef YCBCR2RGB_SAT_CNT_EN
        chk("midrst_satcnt", sat_cnt, 0);
`endif
        tick();
        chk("midrst_ghost1", o_valid, 0);
        tick();
        chk("midrst_ghost2", o_valid, 0);
        send_one("post_rst_white", 8'd235, 8'd128, 8'd128, 24'hFFFFFF);

`ifdef YCBCR2RGB_SAT_CNT_EN
        chk("sat_start", sat_cnt, 0);
        o_ready = 1'b1;
        y = 8'd255; cb = 8'd255; cr = 8'd255; i_valid = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        i_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("sat_stop", sat_cnt, 15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
